mc_bus_bridge: RTL
==================

# mc_bus_bridge

Synchronous bridge between the MCU external memory-controller bus (async, active-low mc_ce/mc_we/mc_oe, 6-bit address, 16-bit data) and the FPGA core clock domain. It sits directly upstream of the SPI data FIFOs and the peripheral register file. It converts each bus access into exactly one single-cycle core-side strobe: FIFO shift, FIFO pop, or register write/read. It also owns a status/control register pair and a FIFO-data interrupt.

## Interface
- DATA_WIDTH, 16, bus and FIFO data width
- ADD_WIDTH, 6, bus address width
- FIFO_ADDR, 6'h00, FIFO data port (write = shift into TX FIFO, read = pop RX FIFO)
- STATUS_ADDR, 6'h01, status register (read; W1C sticky bits)
- CTRL_ADDR, 6'h02, control register (read/write)

- clock  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- mc_ce, mc_we, mc_oe  in  1 each  raw bus strobes, active low, asynchronous to clock
- mc_add  in  ADD_WIDTH  raw bus address
- mc_din  in  DATA_WIDTH  raw bus write data (from pad input)
- mc_dout  out  DATA_WIDTH  registered read data to pad
- mc_dout_oe  out  1  pad output enable = reset & !mc_ce & !mc_oe (combinational)
- fifo_wr_shift  out  1  one-cycle shift into TX FIFO
- fifo_wr_data  out  DATA_WIDTH  TX FIFO data, valid with shift
- fifo_wr_full  in  1  TX FIFO full
- fifo_rd_pop  out  1  one-cycle pop of RX FIFO (first-word-fall-through)
- fifo_rd_data  in  DATA_WIDTH  RX FIFO head
- fifo_rd_nempty  in  1  RX FIFO not empty
- reg_wr_stb  out  1  one-cycle write strobe, other addresses
- reg_wr_addr, reg_rd_addr  out  ADD_WIDTH  latched access address
- reg_wr_data  out  DATA_WIDTH  latched write data
- reg_rd_data  in  DATA_WIDTH  register read data, combinational from reg_rd_addr
- irq  out  1  registered; = irq_en & fifo_rd_nempty

## Operation
- Sync stage: mc_ce, mc_we, mc_oe each pass through a 2-flop synchronizer. Flops reset to 1 (inactive). Synchronized strobes are ce_s, we_s, oe_s. Address and data are sampled raw only while the FSM is in WRITE or READ_SETUP; they are stable by then.
- FSM states: WAIT_IDLE, IDLE, WRITE, READ_SETUP, READ_HOLD. Reset state is WAIT_IDLE.
- WAIT_IDLE -> IDLE when ce_s, we_s and oe_s are all 1. This discards any bus cycle already in flight at reset release.
- IDLE -> WRITE when !ce_s & !we_s. IDLE -> READ_SETUP when !ce_s & !oe_s & we_s. If we and oe are both low, write wins.
- WRITE: latch mc_add and mc_din every cycle. Exit on we_s=1 or ce_s=1: issue the commit strobe for one cycle, then go to IDLE.
  - Commit to FIFO_ADDR: fifo_wr_shift=1 if !fifo_wr_full. If full, no shift and overflow<=1.
  - Commit to STATUS_ADDR: data bit2=1 clears overflow; data bit3=1 clears underflow.
  - Commit to CTRL_ADDR: irq_en<=data[0].
  - Commit to any other address: reg_wr_stb=1.
- READ_SETUP (1 cycle): latch address and load mc_dout, then go to READ_HOLD.
  - FIFO_ADDR: mc_dout = fifo_rd_data if nempty, else 0 and underflow<=1.
  - STATUS_ADDR: mc_dout = {12'b0, underflow, overflow, fifo_wr_full, fifo_rd_nempty}.
  - CTRL_ADDR: mc_dout = {15'b0, irq_en}.
  - Any other address: mc_dout = reg_rd_data.
- READ_HOLD: mc_dout is held. Exit on oe_s=1 or ce_s=1: fifo_rd_pop=1 for one cycle only if the address was FIFO_ADDR and nempty was 1 at READ_SETUP. Then go to IDLE.
- A write to FIFO_ADDR or STATUS_ADDR/CTRL_ADDR never produces reg_wr_stb. All strobes are mutually exclusive and at most one pulse occurs per bus access.
- Reset values: mc_dout=0, all strobes 0, reg addresses/data 0, overflow=underflow=irq_en=irq=0.
- Asserting reset mid-access aborts the access with no strobe.

## Timing
- Strobe latency: a raw edge sampled at clock edge k appears on the synchronized signal after edge k+1. The FSM exits its state at edge k+2, and the strobe is high during the cycle following edge k+2, for exactly 1 cycle.
- Read data latency: the oe falling edge sampled at edge k produces valid mc_dout after edge k+3. The bus oe-to-data time must exceed 4 clock periods.
- The bus requires a minimum of 3 clock periods for each strobe-low time and each strobe-high time. Shorter pulses may be missed; this is not required to be handled.
- Back-to-back accesses are legal as soon as the FSM is back in IDLE, 1 cycle after the strobe.

## Test plan
- Write 16'hA5A5 to 0x00 with FIFO not full -> exactly one fifo_wr_shift, fifo_wr_data=16'hA5A5, 3 cycles after we rises; reg_wr_stb stays 0.
- Write to 0x00 with fifo_wr_full=1 -> no shift; STATUS read returns 16'h0006; writing 16'h0004 to 0x01 clears it, so the next STATUS read returns 16'h0002.
- RX FIFO head=16'h1234, nempty=1: read 0x00 -> mc_dout=16'h1234 while oe is low; one fifo_rd_pop after oe rises, none before.
- Read 0x00 with the RX FIFO empty -> mc_dout=0, no pop, underflow=1 (STATUS bit3).
- Write 16'h0001 to 0x02, then nempty=1 -> irq=1 one cycle later; write 0 to 0x02 -> irq=0. Write 16'hBEEF to 0x19 -> reg_wr_stb pulse with addr 6'h19, data 16'hBEEF.
- Pull reset low mid-write, release it while we is still low -> no strobe; the FSM waits in WAIT_IDLE until the bus is idle, and the next full write commits normally.

Source files
------------

// File: rtl/mc_bus_bridge_if.sv
// Signal bundle between the MCU memory-controller bus, the SPI data FIFOs and
// the peripheral register file, as seen by mc_bus_bridge.
interface mc_bus_bridge_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADD_WIDTH  = 6
);
  logic                  mc_ce;
  logic                  mc_we;
  logic                  mc_oe;
  logic [ADD_WIDTH-1:0]  mc_add;
  logic [DATA_WIDTH-1:0] mc_din;
  logic [DATA_WIDTH-1:0] mc_dout;
  logic                  mc_dout_oe;

  logic                  fifo_wr_shift;
  logic [DATA_WIDTH-1:0] fifo_wr_data;
  logic                  fifo_wr_full;
  logic                  fifo_rd_pop;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_nempty;

  logic                  reg_wr_stb;
  logic [ADD_WIDTH-1:0]  reg_wr_addr;
  logic [ADD_WIDTH-1:0]  reg_rd_addr;
  logic [DATA_WIDTH-1:0] reg_wr_data;
  logic [DATA_WIDTH-1:0] reg_rd_data;

  logic                  irq;

  // Bridge side: receives bus strobes and FIFO/register status.
  modport slave (
    input  mc_ce, mc_we, mc_oe, mc_add, mc_din,
    output mc_dout, mc_dout_oe,
    output fifo_wr_shift, fifo_wr_data, fifo_rd_pop,
    input  fifo_wr_full, fifo_rd_data, fifo_rd_nempty,
    output reg_wr_stb, reg_wr_addr, reg_rd_addr, reg_wr_data,
    input  reg_rd_data,
    output irq
  );

  // Environment side: MCU bus, FIFOs and register file.
  modport master (
    output mc_ce, mc_we, mc_oe, mc_add, mc_din,
    input  mc_dout, mc_dout_oe,
    input  fifo_wr_shift, fifo_wr_data, fifo_rd_pop,
    output fifo_wr_full, fifo_rd_data, fifo_rd_nempty,
    input  reg_wr_stb, reg_wr_addr, reg_rd_addr, reg_wr_data,
    output reg_rd_data,
    input  irq
  );
endinterface

// File: rtl/mc_bus_bridge.sv
// Bridges asynchronous MCU memory-controller accesses into single-cycle core
// strobes (FIFO shift/pop, register write) and owns the status/control pair.
module mc_bus_bridge #(
  parameter int                   DATA_WIDTH  = 16,
  parameter int                   ADD_WIDTH   = 6,
  parameter logic [ADD_WIDTH-1:0] FIFO_ADDR   = ADD_WIDTH'(0),
  parameter logic [ADD_WIDTH-1:0] STATUS_ADDR = ADD_WIDTH'(1),
  parameter logic [ADD_WIDTH-1:0] CTRL_ADDR   = ADD_WIDTH'(2)
) (
  input  logic           clock,
  input  logic           reset,
  mc_bus_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    WRITE,
    READ_SETUP,
    READ_HOLD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [1:0] ce_sync;
  logic [1:0] we_sync;
  logic [1:0] oe_sync;
  logic       ce_s;
  logic       we_s;
  logic       oe_s;
  logic [1:0] prime_cnt;
  logic       primed;

  logic latch_wr;
  logic latch_rd;
  logic commit;
  logic load_dout;
  logic release_rd;

  logic [ADD_WIDTH-1:0]  wr_addr;
  logic [ADD_WIDTH-1:0]  rd_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] dout;
  logic [DATA_WIDTH-1:0] dout_nxt;

  logic shift_q;
  logic shift_nxt;
  logic wstb_q;
  logic wstb_nxt;
  logic pop_q;
  logic pop_nxt;
  logic pop_pend;

  logic overflow;
  logic underflow;
  logic irq_en;
  logic irq_q;

  logic wr_is_fifo;
  logic wr_is_status;
  logic wr_is_ctrl;
  logic rd_is_fifo;
  logic rd_is_status;
  logic rd_is_ctrl;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ce_sync <= 2'b11;
      we_sync <= 2'b11;
      oe_sync <= 2'b11;
    end else begin
      ce_sync <= {ce_sync[0], bus.mc_ce};
      we_sync <= {we_sync[0], bus.mc_we};
      oe_sync <= {oe_sync[0], bus.mc_oe};
    end
  end

  assign ce_s = ce_sync[1];
  assign we_s = we_sync[1];
  assign oe_s = oe_sync[1];

  // The synchronizers hold their reset value for two edges after release; an
  // access still in flight must not be mistaken for an idle bus meanwhile.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prime_cnt <= 2'd0;
    end else if (!prime_cnt[1]) begin
      prime_cnt <= prime_cnt + 2'd1;
    end
  end

  assign primed = prime_cnt[1];

  assign wr_is_fifo   = (wr_addr == FIFO_ADDR);
  assign wr_is_status = (wr_addr == STATUS_ADDR);
  assign wr_is_ctrl   = (wr_addr == CTRL_ADDR);
  assign rd_is_fifo   = (rd_addr == FIFO_ADDR);
  assign rd_is_status = (rd_addr == STATUS_ADDR);
  assign rd_is_ctrl   = (rd_addr == CTRL_ADDR);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= WAIT_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    latch_wr   = 1'b0;
    latch_rd   = 1'b0;
    commit     = 1'b0;
    load_dout  = 1'b0;
    release_rd = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (primed && ce_s && we_s && oe_s) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (!ce_s && !we_s) begin
          state_nxt = WRITE;
        end else if (!ce_s && !oe_s) begin
          latch_rd  = 1'b1;
          state_nxt = READ_SETUP;
        end
      end
      WRITE: begin
        // Raw address/data are no longer guaranteed once the write ends.
        if (we_s || ce_s) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end else begin
          latch_wr = 1'b1;
        end
      end
      READ_SETUP: begin
        latch_rd  = 1'b1;
        load_dout = 1'b1;
        state_nxt = READ_HOLD;
      end
      READ_HOLD: begin
        if (oe_s || ce_s) begin
          release_rd = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase

    shift_nxt = commit && wr_is_fifo && !bus.fifo_wr_full;
    wstb_nxt  = commit && !(wr_is_fifo || wr_is_status || wr_is_ctrl);
    pop_nxt   = release_rd && pop_pend;
  end

  always_comb begin
    dout_nxt = bus.reg_rd_data;
    if (rd_is_fifo) begin
      dout_nxt = bus.fifo_rd_nempty ? bus.fifo_rd_data : '0;
    end else if (rd_is_status) begin
      dout_nxt = {{(DATA_WIDTH-4){1'b0}}, underflow, overflow,
                  bus.fifo_wr_full, bus.fifo_rd_nempty};
    end else if (rd_is_ctrl) begin
      dout_nxt = {{(DATA_WIDTH-1){1'b0}}, irq_en};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_addr  <= '0;
      dout     <= '0;
      pop_pend <= 1'b0;
    end else begin
      if (latch_wr) begin
        wr_addr <= bus.mc_add;
        wr_data <= bus.mc_din;
      end
      if (latch_rd) begin
        rd_addr <= bus.mc_add;
      end
      if (load_dout) begin
        dout     <= dout_nxt;
        pop_pend <= rd_is_fifo && bus.fifo_rd_nempty;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q <= 1'b0;
      wstb_q  <= 1'b0;
      pop_q   <= 1'b0;
    end else begin
      shift_q <= shift_nxt;
      wstb_q  <= wstb_nxt;
      pop_q   <= pop_nxt;
    end
  end

  // Sticky error flags are cleared by writing 1 to their STATUS bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      irq_en    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (commit && wr_is_fifo && bus.fifo_wr_full) begin
        overflow <= 1'b1;
      end else if (commit && wr_is_status && wr_data[2]) begin
        overflow <= 1'b0;
      end
      if (load_dout && rd_is_fifo && !bus.fifo_rd_nempty) begin
        underflow <= 1'b1;
      end else if (commit && wr_is_status && wr_data[3]) begin
        underflow <= 1'b0;
      end
      if (commit && wr_is_ctrl) begin
        irq_en <= wr_data[0];
      end
      irq_q <= irq_en && bus.fifo_rd_nempty;
    end
  end

  assign bus.mc_dout       = dout;
  assign bus.mc_dout_oe    = reset && !bus.mc_ce && !bus.mc_oe;
  assign bus.fifo_wr_shift = shift_q;
  assign bus.fifo_wr_data  = wr_data;
  assign bus.fifo_rd_pop   = pop_q;
  assign bus.reg_wr_stb    = wstb_q;
  assign bus.reg_wr_addr   = wr_addr;
  assign bus.reg_wr_data   = wr_data;
  assign bus.reg_rd_addr   = rd_addr;
  assign bus.irq           = irq_q;

endmodule
